// File: rtl/bpu_pkg.sv
// ---------------------------------------------------------------------------
// bpu_pkg
// Shared definitions for the fetch-side branch prediction unit:
//   - default table geometry (ENTRIES_DEF / INDEX_W_DEF)
//   - 2-bit saturating counter encodings (SNT, WNT, WT, ST)
//   - init-sweep FSM state constants (INIT, READY)
//   - sequential next-PC helper
// ---------------------------------------------------------------------------
package bpu_pkg;

    localparam int ENTRIES_DEF = 64;
    localparam int INDEX_W_DEF = 6;

    // Counter encodings: the MSB alone decides the taken prediction.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Init-sweep FSM states.
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Fall-through fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// ---------------------------------------------------------------------------
// bpu_sat_counter
// Combinational next-state function of a 2-bit saturating branch counter.
// Ports:
//   ctr       in  2  current counter value
//   taken     in  1  resolved outcome
//   ctr_next  out 2  counter after training (saturates at 00 and 11)
// ---------------------------------------------------------------------------
module bpu_sat_counter
    import bpu_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step one state toward the observed outcome, holding at either end.
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
            default: ctr_next = CTR_WNT;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Direct-mapped BTB with 2-bit saturating counters. IF gets a same-cycle
// taken/target prediction; EX returns resolved branches to train the table
// and to count mispredicts. An init sweep clears the table after reset or
// bpu_flush; lookups predict not-taken and updates are dropped until done.
//
// Optional build macro: BPU_BYPASS_EN -- forward a same-cycle update to a
// lookup that hits the entry being written (matching index and tag).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   bpu_flush           invalidate all entries, restart init sweep
//   lookup_valid/pc     fetch PC from IF
//   branch_prediction   predict taken (combinational)
//   predicted_target    next-fetch PC (combinational)
//   bpu_ready           init sweep finished
//   upd_*               resolved branch/jump from EX (single-cycle pulse)
//   mispredict_count    wrapping count of EX mispredicts while ready
// ---------------------------------------------------------------------------
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int INDEX_W = INDEX_W_DEF
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bpu_flush,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        branch_prediction,
    output logic [31:0] predicted_target,
    output logic        bpu_ready,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_is_jump,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] mispredict_count
);

    localparam int TAG_W = 30 - INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);
    localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
        logic             jmp;
    } entry_t;

    // State
    logic [0:0]         state_r;
    logic [INDEX_W-1:0] idx_r;
    logic [31:0]        mispredict_cnt_r;

    // Table storage; only the valid bits need a reset value.
    logic               valid_r  [ENTRIES];
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];
    logic [1:0]         ctr_r    [ENTRIES];
    logic               jmp_r    [ENTRIES];

    // Combinational
    logic               ready_s;
    logic [INDEX_W-1:0] u_idx_s;
    logic [TAG_W-1:0]   u_tag_s;
    entry_t             u_old_s;
    logic               u_hit_s;
    logic [1:0]         u_ctr_next_s;
    logic               wr_en_s;
    logic [INDEX_W-1:0] wr_idx_s;
    entry_t             wr_entry_s;
    logic [INDEX_W-1:0] l_idx_s;
    logic [TAG_W-1:0]   l_tag_s;
    entry_t             l_ent_s;
    logic               l_hit_s;
    logic               l_pred_s;
    logic               unused_s;

    assign ready_s  = (state_r == ST_READY);
    assign unused_s = ^upd_pc[1:0];

    assign u_idx_s = upd_pc[INDEX_W+1:2];
    assign u_tag_s = upd_pc[31:INDEX_W+2];
    assign l_idx_s = lookup_pc[INDEX_W+1:2];
    assign l_tag_s = lookup_pc[31:INDEX_W+2];

    // Read the entry addressed by the resolved instruction.
    always_comb begin
        u_old_s        = '0;
        u_old_s.valid  = valid_r[u_idx_s];
        u_old_s.tag    = tag_r[u_idx_s];
        u_old_s.target = target_r[u_idx_s];
        u_old_s.ctr    = ctr_r[u_idx_s];
        u_old_s.jmp    = jmp_r[u_idx_s];
    end

    assign u_hit_s = u_old_s.valid & (u_old_s.tag == u_tag_s);

    bpu_sat_counter u_sat (
        .ctr      (u_old_s.ctr),
        .taken    (upd_taken),
        .ctr_next (u_ctr_next_s)
    );

    // Single table write port: the init sweep owns it in INIT, training
    // owns it in READY. A flush in the same cycle drops the update.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_idx_s   = idx_r;
        wr_entry_s = '0;
        if (state_r == ST_INIT) begin
            wr_en_s        = 1'b1;
            wr_idx_s       = idx_r;
            wr_entry_s.ctr = CTR_WNT;
        end else if (upd_valid && !bpu_flush) begin
            wr_idx_s   = u_idx_s;
            wr_entry_s = u_old_s;
            if (u_hit_s) begin
                wr_en_s = 1'b1;
                if (upd_is_jump) begin
                    wr_entry_s.ctr    = CTR_ST;
                    wr_entry_s.jmp    = 1'b1;
                    wr_entry_s.target = upd_target;
                end else begin
                    wr_entry_s.ctr = u_ctr_next_s;
                    if (upd_taken) begin
                        wr_entry_s.target = upd_target;
                    end else begin
                        wr_entry_s.target = u_old_s.target;
                    end
                end
            end else if (upd_taken) begin
                // Allocate, replacing whatever aliased into this slot.
                wr_en_s           = 1'b1;
                wr_entry_s.valid  = 1'b1;
                wr_entry_s.tag    = u_tag_s;
                wr_entry_s.target = upd_target;
                wr_entry_s.jmp    = upd_is_jump;
                wr_entry_s.ctr    = upd_is_jump ? CTR_ST : CTR_WT;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Valid bits: cleared asynchronously by reset, then via the write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[wr_idx_s] <= wr_entry_s.valid;
        end
    end

    // Entry payload storage; no reset needed, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_r[wr_idx_s]    <= wr_entry_s.tag;
            target_r[wr_idx_s] <= wr_entry_s.target;
            ctr_r[wr_idx_s]    <= wr_entry_s.ctr;
            jmp_r[wr_idx_s]    <= wr_entry_s.jmp;
        end
    end

    // Init-sweep FSM: ENTRIES write cycles, then READY until the next flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
            idx_r   <= '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (bpu_flush) begin
                        idx_r <= '0;
                    end else if (idx_r == LAST_IDX) begin
                        state_r <= ST_READY;
                        idx_r   <= '0;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_READY: begin
                    if (bpu_flush) begin
                        state_r <= ST_INIT;
                        idx_r   <= '0;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    // Mispredict counter: survives flush, wraps at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_cnt_r <= 32'd0;
        end else if (ready_s && upd_valid && upd_mispredict) begin
            mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
        end
    end

    // Read the entry addressed by the fetch PC, optionally forwarding a
    // same-cycle write to the same index with the same tag.
    always_comb begin
        l_ent_s        = '0;
        l_ent_s.valid  = valid_r[l_idx_s];
        l_ent_s.tag    = tag_r[l_idx_s];
        l_ent_s.target = target_r[l_idx_s];
        l_ent_s.ctr    = ctr_r[l_idx_s];
        l_ent_s.jmp    = jmp_r[l_idx_s];
`ifdef BPU_BYPASS_EN
        if (ready_s && wr_en_s && (wr_idx_s == l_idx_s) && (wr_entry_s.tag == l_tag_s)) begin
            l_ent_s = wr_entry_s;
        end else begin
            l_ent_s.valid = valid_r[l_idx_s];
        end
`endif
    end

    assign l_hit_s  = ready_s & lookup_valid & l_ent_s.valid & (l_ent_s.tag == l_tag_s);
    assign l_pred_s = l_hit_s & (l_ent_s.jmp | l_ent_s.ctr[1]);

    assign branch_prediction = l_pred_s;
    assign predicted_target  = l_pred_s ? l_ent_s.target : next_seq_pc(lookup_pc);
    assign bpu_ready         = ready_s;
    assign mispredict_count  = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed scenarios followed by random traffic. A driver issues one input
// set per cycle and pushes the reference model's expected outputs into a
// queue; an independent monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int ENTRIES = 64;
    localparam int INDEX_W = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bpu_flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        branch_prediction;
    logic [31:0] predicted_target;
    logic        bpu_ready;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic        upd_is_jump = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] mispredict_count;

    always #5 clk = ~clk;

    branch_predict_unit #(.ENTRIES(ENTRIES), .INDEX_W(INDEX_W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bpu_flush         (bpu_flush),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .branch_prediction (branch_prediction),
        .predicted_target  (predicted_target),
        .bpu_ready         (bpu_ready),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .upd_is_jump       (upd_is_jump),
        .upd_target        (upd_target),
        .upd_mispredict    (upd_mispredict),
        .mispredict_count  (mispredict_count)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          ready;
        bit          pred;
        logic [31:0] tgt;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle_no = 0;

    // ---------------- reference model ----------------
    // Each slot remembers the full PC of the branch that owns it; an
    // access hits when the PCs agree above the index bits.
    bit          m_valid [ENTRIES];
    logic [31:0] m_owner [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_jmp   [ENTRIES];
    int          m_init_left;
    logic [31:0] m_cnt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (INDEX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_init_left = ENTRIES;
        m_cnt = 32'd0;
    endtask

    // Contents the resolved branch would leave in its slot, if it writes.
    task automatic model_next(input logic [31:0] upc, input bit ut, input bit uj,
                              input logic [31:0] utgt, output bit we, output bit nv,
                              output logic [31:0] nown, output logic [31:0] ntgt,
                              output int nctr, output bit njmp);
        int i;
        bit hit;
        i    = idx_of(upc);
        hit  = m_valid[i] && (tag_of(m_owner[i]) == tag_of(upc));
        we   = 1'b0;
        nv   = m_valid[i];
        nown = m_owner[i];
        ntgt = m_tgt[i];
        nctr = m_ctr[i];
        njmp = m_jmp[i];
        if (hit) begin
            we = 1'b1;
            if (uj) begin
                nctr = 3; njmp = 1'b1; ntgt = utgt;
            end else begin
                nctr = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (ut) ntgt = utgt;
            end
        end else if (ut) begin
            we = 1'b1; nv = 1'b1; nown = upc; ntgt = utgt; njmp = uj;
            nctr = uj ? 3 : 2;
        end
    endtask

    // One clock of stimulus: drive, predict outputs, advance the model.
    task automatic cyc(input bit rst, input bit fl, input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input bit ut, input bit uj,
                       input logic [31:0] utgt, input bit um);
        bit ready, act, we, nv, njmp, ev, ej, pred;
        logic [31:0] nown, ntgt, eo, et;
        int nctr, ec, li, ui;
        exp_t e;
        @(posedge clk);
        #1;
        cycle_no++;
        reset_n = !rst; bpu_flush = fl;
        lookup_valid = lv; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_is_jump = uj;
        upd_target = utgt; upd_mispredict = um;
        if (rst) model_reset();
        ready = !rst && (m_init_left == 0);
        act = ready && uv && !fl;
        model_next(upc, ut, uj, utgt, we, nv, nown, ntgt, nctr, njmp);
        li = idx_of(lpc);
        ui = idx_of(upc);
        ev = m_valid[li]; eo = m_owner[li]; et = m_tgt[li]; ec = m_ctr[li]; ej = m_jmp[li];
`ifdef BPU_BYPASS_EN
        if (act && we && (ui == li) && (tag_of(nown) == tag_of(lpc))) begin
            ev = nv; eo = nown; et = ntgt; ec = nctr; ej = njmp;
        end
`endif
        pred = ready && lv && ev && (tag_of(eo) == tag_of(lpc)) && (ej || ec >= 2);
        e.ready = ready;
        e.pred  = pred;
        e.tgt   = pred ? et : lpc + 32'd4;
        e.cnt   = m_cnt;
        e.cyc   = cycle_no;
        exp_q.push_back(e);
        // Effect of the coming clock edge.
        if (!rst) begin
            if (m_init_left > 0) begin
                m_init_left = fl ? ENTRIES : m_init_left - 1;
            end else begin
                if (uv && um) m_cnt = m_cnt + 32'd1;
                if (fl) begin
                    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
                    m_init_left = ENTRIES;
                end else if (act && we) begin
                    m_valid[ui] = nv; m_owner[ui] = nown; m_tgt[ui] = ntgt;
                    m_ctr[ui] = nctr; m_jmp[ui] = njmp;
                end
            end
        end
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(1'b0, 1'b0, 1'b1, pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input bit j,
                       input logic [31:0] tgt, input bit m);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, pc, t, j, tgt, m);
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] base;
        case ($urandom_range(0, 7))
            0: base = 32'h0000_0200;
            1: base = 32'h0000_0300;
            2: base = 32'h0000_0204;
            3: base = 32'h0000_0600;
            4: base = 32'h0001_0200;
            5: base = 32'hFFFF_FFFC;
            default: base = $urandom & 32'h0000_03FC;
        endcase
        return base | 32'($urandom_range(0, 3));
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                       input int c);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp_v);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("bpu_ready", {31'd0, bpu_ready}, {31'd0, e.ready}, e.cyc);
            chk("branch_prediction", {31'd0, branch_prediction}, {31'd0, e.pred}, e.cyc);
            chk("predicted_target", predicted_target, e.tgt, e.cyc);
            chk("mispredict_count", mispredict_count, e.cnt, e.cyc);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit lv, uv, ut, uj, um, fl, rs;
        model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_owner[i] = 32'd0; m_tgt[i] = 32'd0; m_ctr[i] = 1; m_jmp[i] = 1'b0;
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        // Init sweep: not ready for 64 cycles, then ready.
        repeat (66) look(32'h100);
        // Miss-taken allocate, then one not-taken.
        upd(32'h200, 1'b1, 1'b0, 32'h400, 1'b1);
        look(32'h200);
        upd(32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
        look(32'h200);
        // Saturation at 0x300.
        repeat (4) upd(32'h300, 1'b1, 1'b0, 32'h700, 1'b0);
        look(32'h300);
        upd(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h300);
        repeat (2) upd(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h300);
        upd(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h300);
        // Alias: 0x200 and 0x300 share index 0.
        upd(32'h200, 1'b1, 1'b0, 32'h440, 1'b0);
        upd(32'h300, 1'b1, 1'b0, 32'h740, 1'b0);
        look(32'h200);
        look(32'h300);
        // Jump, then flush.
        upd(32'h500, 1'b1, 1'b1, 32'h800, 1'b1);
        look(32'h500);
        cyc(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (66) look(32'h500);
        // Same-cycle update and lookup at 0x600.
        cyc(1'b0, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600, 1'b1, 1'b0, 32'h900, 1'b0);
        look(32'h600);
        // Reset mid-operation, then three mispredict pulses from zero.
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 32'h600, 1'b1, 32'h600, 1'b1, 1'b0, 32'h900, 1'b1);
        repeat (65) look(32'h600);
        repeat (3) upd(32'h700, 1'b0, 1'b0, 32'h0, 1'b1);
        look(32'h600);
        look(32'hFFFF_FFFC);
        // Random traffic with occasional flushes and one reset.
        for (int n = 0; n < 3000; n++) begin
            lv = ($urandom_range(0, 3) != 0);
            uv = ($urandom_range(0, 2) == 0);
            uj = ($urandom_range(0, 4) == 0);
            ut = uj ? 1'b1 : 1'($urandom_range(0, 1));
            um = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 399) == 0);
            rs = (n >= 1500 && n < 1502);
            cyc(rs, fl, lv, pick_pc(), uv, pick_pc(), ut, uj, $urandom, um);
        end
        @(negedge clk);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Fetch-side branch prediction unit: the producer of branch_prediction/predicted_target and the consumer of resolved-branch updates returned from the EX stage.
- IF presents the fetch PC and gets a same-cycle taken/target prediction from a direct-mapped BTB with 2-bit saturating counters.
- EX reports the actual outcome; the unit trains its tables and counts mispredicts.
- Includes an init-sweep FSM that clears tables after reset or flush.

Parameters:
- ENTRIES, 64, number of BTB/BHT entries (power of 2, >= 4).
- INDEX_W, 6, log2(ENTRIES); index = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2].

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- bpu_flush  in  1  soft invalidate of all entries; restarts the init sweep.
- lookup_valid  in  1  IF is presenting a fetch PC.
- lookup_pc  in  32  fetch PC, word aligned.
- branch_prediction  out  1  predict taken.
- predicted_target  out  32  next-fetch PC.
- bpu_ready  out  1  init sweep done; tables valid.
- upd_valid  in  1  resolved branch/jump from EX (single-cycle pulse).
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_is_jump  in  1  unconditional jump.
- upd_target  in  32  resolved target.
- upd_mispredict  in  1  EX-detected mispredict.
- mispredict_count  out  32  wrapping mispredict counter.

Behaviour:
- Entry fields: valid, tag[31-INDEX_W-2:0], target[31:0], ctr[1:0], jmp.
- Reset: valid bits all 0 (async); FSM=INIT, sweep idx=0; bpu_ready=0; mispredict_count=0.
- Reset asserted mid-operation aborts everything immediately; tables are invalid and the sweep restarts on release.
- FSM INIT:
  - Each cycle write entry[idx]: valid=0, ctr=2'b01, jmp=0; idx++.
  - After writing idx=ENTRIES-1, go to READY. INIT lasts exactly ENTRIES cycles after reset release; bpu_ready rises the cycle after the last write.
- FSM READY:
  - bpu_flush=1 -> INIT with idx=0.
  - bpu_flush during INIT -> idx=0 (sweep restarts).
- Lookup (combinational from registered tables):
  - hit = ready & lookup_valid & valid[i] & tag match.
  - branch_prediction = hit & (jmp[i] | ctr[i][1]).
  - predicted_target = branch_prediction ? target[i] : lookup_pc+4 (32-bit wrap).
  - When !ready or !lookup_valid: prediction=0, target=lookup_pc+4.
- Update (READY only; ignored in INIT or when bpu_flush=1 the same cycle):
  - Hit, conditional branch: ctr saturating +1 if taken (max 11), -1 if not (min 00); target<=upd_target if taken.
  - Hit, jump: ctr<=11, jmp<=1, target<=upd_target.
  - Miss, taken: allocate/replace entry: valid=1, tag, target, jmp=upd_is_jump, ctr = jump ? 11 : 10.
  - Miss, not taken: no write.
- Update latency: visible to lookups on the cycle after upd_valid. Same-cycle lookup to the same index sees the old contents unless BPU_BYPASS_EN is defined.
- mispredict_count: +1 on upd_valid & upd_mispredict in READY; wraps at 2^32. Not cleared by flush.
- Unaligned pc[1:0] is ignored.

Optional Feature:
- Macro BPU_BYPASS_EN.
  - Defined: when an update in the same cycle targets the lookup index and would write a matching tag, the lookup outputs reflect the post-update entry (new ctr/target/jmp/valid), i.e. a combinational forward.
  - Undefined: the lookup sees pre-update contents.

Decomposition:
- Shared package bpu_pkg: ENTRIES/INDEX_W defaults, the entry struct (or field widths), ctr encoding constants (SNT=00, WNT=01, WT=10, ST=11), FSM state enum (INIT, READY).
- One natural sub-module: bpu_sat_counter, a combinational 2-bit saturating next-state function (ctr, taken) -> ctr_next.

Test Plan:
- Reset release: bpu_ready=0 for 64 cycles, 1 on cycle 65; lookup 0x100 during INIT -> prediction 0, target 0x104.
- Miss taken: upd pc=0x200, taken=1, target=0x400 -> next cycle lookup 0x200 gives prediction 1, target 0x400 (ctr=10). Then one not-taken update -> prediction 0, target 0x204.
- Saturation: 4 taken updates at 0x300 -> ctr=11; 1 not-taken -> still predicted taken; 2 more not-taken -> ctr=00, not taken, no underflow.
- Alias: allocate 0x200, then taken update at 0x200+ENTRIES*4 (0x300) -> lookup 0x200 misses (target 0x204), lookup 0x300 hits.
- Jump plus flush: jump update at 0x500 -> 0x800 gives prediction 1; assert bpu_flush -> bpu_ready=0 for 64 cycles, then lookup 0x500 misses; mispredict_count retained.
- Same-cycle update+lookup at 0x600 (taken, miss) -> prediction 0 without BPU_BYPASS_EN, 1/target upd_target with it; 3 upd_mispredict pulses -> mispredict_count=3.
